// File: rtl/chien_sched_pkg.sv
// Shared definitions for the Chien-search scheduler: state encoding, default
// code parameters and the width helper used for degree/count fields.
package chien_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time width computation.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int unsigned M_DEF = 4;
  localparam int unsigned T_DEF = 3;
  localparam int unsigned N_DEF = 15;
  localparam int unsigned CNT_W = clog2(T_DEF + 2);

endpackage

// File: rtl/chien_sched.sv
// Sequences a Chien-search datapath: loads sigma(x), steps through positions
// j = 0..N-1 under downstream backpressure, and reports root count / failure.
module chien_sched
  import chien_sched_pkg::*;
#(
  parameter int unsigned M = M_DEF,
  parameter int unsigned T = T_DEF,
  parameter int unsigned N = N_DEF,
  localparam int unsigned CW = clog2(T + 2),
  localparam int unsigned SW = M * (T + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sigma_valid,
  output logic          sigma_ready,
  input  logic [SW-1:0] sigma_in,
  input  logic [CW-1:0] sigma_deg,
  output logic          ch_start,
  output logic [SW-1:0] cNout,
  output logic          cei,
  input  logic          err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_pos,
  output logic          out_err,
  output logic          done,
  output logic [CW-1:0] err_count,
  output logic          fail
);

  localparam logic [M-1:0]  LAST_POS = M'(N - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(T + 1);
  localparam logic [CW-1:0] DEG_MAX  = CW'(T);

  state_e        state_q, state_d;
  logic [M-1:0]  j_q, j_d;
  logic [CW-1:0] deg_q, deg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fail_q, fail_d;

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      deg_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      deg_q   <= deg_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    deg_d       = deg_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    sigma_ready = 1'b0;
    ch_start    = 1'b0;
    cei         = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sigma_ready = 1'b1;
        ch_start    = sigma_valid;
        if (sigma_valid) begin
          deg_d   = sigma_deg;
          cnt_d   = '0;
          fail_d  = 1'b0;
          j_d     = '0;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        out_valid = 1'b1;
        // Datapath and position counter advance only on an accepted result.
        cei       = out_ready;
        if (out_ready) begin
          if (err && (cnt_q < CNT_MAX)) cnt_d = cnt_q + CW'(1);
          if (j_q == LAST_POS) state_d = ST_FINISH;
          else                 j_d     = j_q + M'(1);
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        fail_d  = (cnt_q != deg_q) || (deg_q > DEG_MAX);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cNout     = sigma_in;
  assign out_pos   = j_q;
  assign out_err   = err;
  assign err_count = cnt_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_chien_sched.sv
// Directed bench for chien_sched; a behavioural datapath flags roots from a
// per-test position mask and advances only on ch_start/cei.
module tb_chien_sched;

  localparam int M  = 4;
  localparam int T  = 3;
  localparam int N  = 15;
  localparam int CW = 3;
  localparam int SW = M * (T + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          sigma_valid;
  logic          sigma_ready;
  logic [SW-1:0] sigma_in;
  logic [CW-1:0] sigma_deg;
  logic          ch_start;
  logic [SW-1:0] cNout;
  logic          cei;
  logic          err;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_pos;
  logic          out_err;
  logic          done;
  logic [CW-1:0] err_count;
  logic          fail;

  int checks = 0;
  int errors = 0;

  logic [31:0] root_mask;
  logic [4:0]  dp_pos;

  // results of the last do_search
  int          r_hs, r_order_bad, r_cei_cnt, r_cei_bad, r_lat;
  logic [31:0] r_seen;
  bit          r_timeout, r_ch_ok;
  logic [CW-1:0] r_cnt;
  logic        r_fail, r_rdy;

  chien_sched dut (
    .clk(clk), .reset(reset),
    .sigma_valid(sigma_valid), .sigma_ready(sigma_ready),
    .sigma_in(sigma_in), .sigma_deg(sigma_deg),
    .ch_start(ch_start), .cNout(cNout), .cei(cei), .err(err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pos(out_pos), .out_err(out_err),
    .done(done), .err_count(err_count), .fail(fail)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: position pointer loaded by ch_start, stepped by cei.
  always @(posedge clk) begin
    if (ch_start)  dp_pos <= 5'd0;
    else if (cei)  dp_pos <= dp_pos + 5'd1;
  end
  assign err = root_mask[dp_pos];

  // Runs one full search starting at posedge+2 in IDLE; ends at posedge+2 back in IDLE.
  task automatic do_search(input logic [31:0] mask, input logic [CW-1:0] deg, input bit rnd);
    root_mask   = mask;
    sigma_in    = 16'h1234;
    sigma_deg   = deg;
    sigma_valid = 1'b1;
    out_ready   = rnd ? 1'b0 : 1'b1;
    #1;
    r_ch_ok = (ch_start === 1'b1) && (cNout === 16'h1234) && (sigma_ready === 1'b1);
    @(posedge clk); #1;
    sigma_valid = 1'b0;
    r_hs = 0; r_order_bad = 0; r_cei_cnt = 0; r_cei_bad = 0; r_lat = 0;
    r_seen = '0; r_timeout = 1'b1;
    for (int c = 0; c < 300; c++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      r_lat++;
      if (out_valid && out_ready) begin
        if (out_pos !== 4'(r_hs)) r_order_bad++;
        r_seen[out_pos] = out_err;
        r_hs++;
      end
      if (cei) r_cei_cnt++;
      if (cei && !out_ready) r_cei_bad++;
      if (done === 1'b1) begin
        r_timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #2;
    r_cnt  = err_count;
    r_fail = fail;
    r_rdy  = sigma_ready;
  endtask

  task automatic test_reset();
    checks++;
    if (sigma_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || cei !== 1'b0 || ch_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%b ov=%b done=%b cei=%b cs=%b, want 1 0 0 0 0",
               sigma_ready, out_valid, done, cei, ch_start);
    end
    checks++;
    if (err_count !== 3'd0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: err_count=%0d fail=%b, want 0 0", err_count, fail);
    end
  endtask

  task automatic test_two_roots();
    do_search(32'h0000_0204, 3'd2, 1'b0);
    checks++;
    if (!r_ch_ok) begin errors++; $display("FAIL two_accept: ch_start/cNout/sigma_ready wrong on accept"); end
    checks++;
    if (r_timeout || r_lat !== 16) begin errors++; $display("FAIL two_latency: timeout=%b lat=%0d, want 0 16", r_timeout, r_lat); end
    checks++;
    if (r_hs !== 15 || r_order_bad !== 0) begin errors++; $display("FAIL two_order: hs=%0d bad=%0d, want 15 0", r_hs, r_order_bad); end
    checks++;
    if (r_seen !== 32'h0000_0204) begin errors++; $display("FAIL two_roots: seen=%h want 00000204", r_seen); end
    checks++;
    if (r_cnt !== 3'd2 || r_fail !== 1'b0 || r_rdy !== 1'b1) begin
      errors++; $display("FAIL two_result: cnt=%0d fail=%b rdy=%b, want 2 0 1", r_cnt, r_fail, r_rdy);
    end
  endtask

  task automatic test_backpressure();
    do_search(32'h0000_0204, 3'd2, 1'b1);
    checks++;
    if (r_timeout || r_hs !== 15 || r_order_bad !== 0) begin
      errors++; $display("FAIL bp_order: timeout=%b hs=%0d bad=%0d, want 0 15 0", r_timeout, r_hs, r_order_bad);
    end
    checks++;
    if (r_seen !== 32'h0000_0204) begin errors++; $display("FAIL bp_roots: seen=%h want 00000204", r_seen); end
    checks++;
    if (r_cei_cnt !== 15 || r_cei_bad !== 0) begin
      errors++; $display("FAIL bp_cei: pulses=%0d stalled=%0d, want 15 0", r_cei_cnt, r_cei_bad);
    end
    checks++;
    if (r_cnt !== 3'd2 || r_fail !== 1'b0) begin errors++; $display("FAIL bp_result: cnt=%0d fail=%b, want 2 0", r_cnt, r_fail); end
  endtask

  task automatic test_deg_mismatch();
    out_ready = 1'b1;
    do_search(32'h0000_0040, 3'd2, 1'b0);
    checks++;
    if (r_seen !== 32'h0000_0040) begin errors++; $display("FAIL mis_roots: seen=%h want 00000040", r_seen); end
    checks++;
    if (r_cnt !== 3'd1 || r_fail !== 1'b1) begin errors++; $display("FAIL mis_result: cnt=%0d fail=%b, want 1 1", r_cnt, r_fail); end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (err_count !== 3'd1 || fail !== 1'b1 || sigma_ready !== 1'b1) begin
      errors++; $display("FAIL mis_hold: cnt=%0d fail=%b rdy=%b, want 1 1 1", err_count, fail, sigma_ready);
    end
  endtask

  task automatic test_no_error();
    do_search(32'h0, 3'd0, 1'b0);
    checks++;
    if (r_seen !== 32'h0 || r_hs !== 15) begin errors++; $display("FAIL noerr_roots: seen=%h hs=%0d, want 0 15", r_seen, r_hs); end
    checks++;
    if (r_cnt !== 3'd0 || r_fail !== 1'b0) begin errors++; $display("FAIL noerr_result: cnt=%0d fail=%b, want 0 0", r_cnt, r_fail); end
  endtask

  task automatic test_saturation();
    // five roots with deg 4: count saturates at T+1=4, deg > T forces fail
    do_search(32'h0000_0929, 3'd4, 1'b0);
    checks++;
    if (r_seen !== 32'h0000_0929) begin errors++; $display("FAIL sat_roots: seen=%h want 00000929", r_seen); end
    checks++;
    if (r_cnt !== 3'd4 || r_fail !== 1'b1) begin errors++; $display("FAIL sat_result: cnt=%0d fail=%b, want 4 1", r_cnt, r_fail); end
  endtask

  task automatic test_mid_reset();
    bit hit, saw_done, saw_valid;
    root_mask   = 32'h0000_0204;
    sigma_deg   = 3'd2;
    sigma_valid = 1'b1;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    sigma_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (out_valid && out_pos == 4'd7) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach: position 7 never presented"); end
    reset = 1'b1;
    #1;
    checks++;
    if (sigma_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state: rdy=%b ov=%b done=%b, want 1 0 0", sigma_ready, out_valid, done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    saw_done = 1'b0; saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (done) saw_done = 1'b1;
      if (out_valid) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (saw_done || saw_valid) begin errors++; $display("FAIL mid_idle: done_seen=%b valid_seen=%b, want 0 0", saw_done, saw_valid); end
    do_search(32'h0000_0204, 3'd2, 1'b0);
    checks++;
    if (r_timeout || r_seen !== 32'h0000_0204 || r_cnt !== 3'd2 || r_fail !== 1'b0) begin
      errors++; $display("FAIL mid_fresh: timeout=%b seen=%h cnt=%0d fail=%b, want 0 00000204 2 0",
                         r_timeout, r_seen, r_cnt, r_fail);
    end
  endtask

  task automatic test_back_to_back();
    int acc[8];
    int n, bad;
    bit fin;
    root_mask   = 32'h0;
    sigma_deg   = 3'd0;
    out_ready   = 1'b1;
    sigma_valid = 1'b1;
    n = 0; bad = 0;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (ch_start) begin
        if (n < 8) acc[n] = c;
        n++;
      end
      if (ch_start !== sigma_ready) bad++;
      @(posedge clk); #2;
    end
    sigma_valid = 1'b0;
    checks++;
    if (n !== 4 || bad !== 0) begin errors++; $display("FAIL b2b_count: accepts=%0d stray=%0d, want 4 0", n, bad); end
    checks++;
    if (n >= 4 && (acc[1] - acc[0] !== 17 || acc[2] - acc[1] !== 17 || acc[3] - acc[2] !== 17)) begin
      errors++; $display("FAIL b2b_spacing: accepts at %0d %0d %0d %0d, want spacing 17", acc[0], acc[1], acc[2], acc[3]);
    end
    fin = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin fin = 1'b1; break; end
      @(posedge clk); #2;
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL b2b_drain: final search never finished"); end
    @(posedge clk); #2;
  endtask

  initial begin
    reset = 1'b1; sigma_valid = 1'b0; sigma_in = '0; sigma_deg = '0;
    out_ready = 1'b0; root_mask = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    test_reset();
    test_two_roots();
    test_backpressure();
    test_deg_mismatch();
    test_no_error();
    test_saturation();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chien_sched.md
Name: chien_sched

Overview:
- Controller that sequences one Chien-search datapath, which evaluates the error-locator polynomial sigma(x) at alpha^j, j = 0..N-1, one step per enable.
- Accepts a locator polynomial from the Berlekamp-Massey stage and loads the datapath.
- Steps the datapath under downstream backpressure and streams one root/no-root flag per position.
- Reports the error count and a decode-failure flag when the search ends.

Parameters:
- M, 4, field width; GF(2^M).
- T, 3, correction capability; sigma has T+1 coefficients.
- N, 15, codeword length (positions searched); 1 <= N <= 2^M-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sigma_valid  in  1  locator polynomial and degree are valid
- sigma_ready  out  1  scheduler can accept a polynomial
- sigma_in  in  M*(T+1)  coefficients, coeff i at [i*M+:M]
- sigma_deg  in  clog2(T+2)  degree of sigma
- ch_start  out  1  load pulse to the datapath
- cNout  out  M*(T+1)  coefficients routed to the datapath (pass-through of sigma_in)
- cei  out  1  datapath step enable
- err  in  1  datapath result; 1 when sigma(alpha^j) == 0
- out_valid  out  1  position result valid
- out_ready  in  1  downstream accepts the position result
- out_pos  out  M  current j (exponent of the evaluated point)
- out_err  out  1  err for out_pos
- done  out  1  one-cycle end-of-search pulse
- err_count  out  clog2(T+2)  roots found, held until the next load
- fail  out  1  count/degree mismatch, held until the next load

Behaviour:
- Reset values:
  - State IDLE; j = 0.
  - sigma_ready = 1; ch_start, cei, out_valid, done, fail = 0.
  - err_count = 0; deg register = 0.
  - Reset asserted at any point, including mid-search, abandons the search with no done pulse.
- States: IDLE, SEARCH, FINISH.
- IDLE:
  - sigma_ready = 1.
  - ch_start = sigma_valid (combinational), so the datapath loads cNout on the accepting edge.
  - cNout = sigma_in directly. The upstream block holds sigma_in stable while sigma_valid is high.
  - On accept: latch sigma_deg; clear err_count and fail; j <= 0; go to SEARCH.
- SEARCH:
  - sigma_ready = 0; out_valid = 1; out_pos = j; out_err = err.
  - cei = out_ready, so a stalled output freezes the datapath and j together.
  - On out_valid & out_ready:
    - if err = 1, err_count <= min(err_count + 1, T+1) (saturates at T+1);
    - if j = N-1, go to FINISH; otherwise j <= j + 1.
  - The final step's cei advances the datapath harmlessly; it is reloaded before next use.
- FINISH (one cycle):
  - done = 1; out_valid = 0.
  - fail <= (err_count != deg) or (deg > T). The err_count used already includes the final position.
  - Go to IDLE. sigma_ready rises the cycle after done.
- Timing:
  - First result (j = 0) is presented the cycle after accept.
  - With out_ready held at 1, the search takes N cycles, then done; the next accept is possible 1 cycle after done.
  - Minimum accept-to-accept period is N + 2 cycles.
- Boundaries:
  - out_ready low on the accept cycle does not matter; the stall applies only in SEARCH.
  - out_ready toggling: each position is emitted exactly once, in order, with no duplicates or skips.
  - N = 1: a single result, then FINISH.
  - sigma_valid while busy: ignored, because sigma_ready = 0.
  - deg = 0 with no roots: fail = 0 (no-error word).
  - err_count and fail stay stable from done until the next accept.

Decomposition:
- Shared package (bch.vh) holds:
  - state encodings (IDLE / SEARCH / FINISH);
  - the clog2 helper;
  - count width = clog2(T+2).
- Instance the existing chien block beside this scheduler at top level. No sub-module is needed inside; the position counter stays inline.

Test Plan:
1. M=4, T=3, N=15, sigma with roots at j=2 and j=9, deg=2, out_ready=1 -> out_err high only at out_pos 2 and 9; done 16 cycles after accept; err_count=2, fail=0.
2. Same sigma, out_ready random 50% -> identical sequence of (out_pos, out_err) over 15 handshakes; cei pulses exactly 15 times; cei is never high while out_ready=0.
3. sigma with 1 root, deg=2 -> err_count=1, fail=1 at done.
4. All-zero-error word (sigma = 1, deg=0) -> no out_err; err_count=0, fail=0.
5. reset asserted at j=7 -> next cycle is IDLE with sigma_ready=1 and out_valid=0; no done. A fresh polynomial then completes normally.
6. sigma_valid held high continuously -> accepts spaced exactly N+2 cycles apart; ch_start is high only on accept cycles.
